complex_mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one complex-number multiplier core between NR_REQ requesters.
- Each requester uses an op_val/op_ready operand handshake and a res_val/res_ready result handshake.
- The arbiter accepts one transaction at a time, drives the core through the same handshakes, and returns the result to the granted requester.
- It sits between the requester ports and the multiplier core's op/res interface.

---
 rtl/complex_mult_arbiter.sv | 143 ++++++++++++++
 tb/tb_complex_mult_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mult_arbiter.sv
// Round-robin arbiter sharing one complex multiplier core between NR_REQ requesters.
// One transaction in flight: accept operands, issue to core, collect result, return it.
module complex_mult_arbiter #(
    parameter int NR_REQ = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = 2*DATA_W+2,
    localparam int IDW   = $clog2(NR_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sw_rst,
    input  logic [NR_REQ-1:0]          req_op_val,
    output logic [NR_REQ-1:0]          req_op_ready,
    input  logic [NR_REQ*2*DATA_W-1:0] req_op_a,
    input  logic [NR_REQ*2*DATA_W-1:0] req_op_b,
    output logic [NR_REQ-1:0]          req_res_val,
    input  logic [NR_REQ-1:0]          req_res_ready,
    output logic [2*RES_W-1:0]         req_res,
    output logic                       core_op_val,
    input  logic                       core_op_ready,
    output logic [2*DATA_W-1:0]        core_op_a,
    output logic [2*DATA_W-1:0]        core_op_b,
    input  logic                       core_res_val,
    output logic                       core_res_ready,
    input  logic [2*RES_W-1:0]         core_res,
    output logic                       busy,
    output logic [IDW-1:0]             grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RES,
        RETURN
    } state_t;

    state_t                r_state;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_grant;
    logic [2*DATA_W-1:0]   r_op_a;
    logic [2*DATA_W-1:0]   r_op_b;
    logic [2*RES_W-1:0]    r_res;
    logic                  r_core_op_val;
    logic                  r_core_res_ready;
    logic [NR_REQ-1:0]     r_req_res_val;
    logic                  r_busy;

    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [IDW-1:0]        w_next_ptr;
    int                    w_idx;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = NR_REQ-1; k >= 0; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NR_REQ;
            if (req_op_val[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
        w_next_ptr = (int'(w_win) == NR_REQ-1) ? '0 : w_win + 1'b1;
    end

    assign req_op_ready = (r_state == IDLE && w_found && !rst && !sw_rst)
                        ? (NR_REQ'(1) << w_win) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_rr_ptr         <= '0;
            r_grant          <= '0;
            r_op_a           <= '0;
            r_op_b           <= '0;
            r_res            <= '0;
            r_core_op_val    <= 1'b0;
            r_core_res_ready <= 1'b0;
            r_req_res_val    <= '0;
            r_busy           <= 1'b0;
        end else if (sw_rst) begin
            r_state          <= IDLE;
            r_rr_ptr         <= '0;
            r_grant          <= '0;
            r_op_a           <= '0;
            r_op_b           <= '0;
            r_res            <= '0;
            r_core_op_val    <= 1'b0;
            r_core_res_ready <= 1'b0;
            r_req_res_val    <= '0;
            r_busy           <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_op_a        <= req_op_a[w_win*2*DATA_W +: 2*DATA_W];
                        r_op_b        <= req_op_b[w_win*2*DATA_W +: 2*DATA_W];
                        r_grant       <= w_win;
                        r_rr_ptr      <= w_next_ptr;
                        r_core_op_val <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_op_ready) begin
                        r_core_op_val    <= 1'b0;
                        r_core_res_ready <= 1'b1;
                        r_state          <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (core_res_val) begin
                        r_res            <= core_res;
                        r_core_res_ready <= 1'b0;
                        r_req_res_val    <= NR_REQ'(1) << r_grant;
                        r_state          <= RETURN;
                    end
                end
                RETURN: begin
                    if (req_res_ready[r_grant]) begin
                        r_req_res_val <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_op_val    = r_core_op_val;
    assign core_op_a      = r_op_a;
    assign core_op_b      = r_op_b;
    assign core_res_ready = r_core_res_ready;
    assign req_res_val    = r_req_res_val;
    assign req_res        = r_res;
    assign busy           = r_busy;
    assign grant_id       = r_grant;

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Randomized bench for complex_mult_arbiter with a transaction-level reference
// model, a behavioural multiplier core and directed corner scenarios.
module tb_complex_mult_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 2*DW+2;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic              sw_rst;
    logic [N-1:0]      req_op_val;
    logic [N-1:0]      req_op_ready;
    logic [N*2*DW-1:0] req_op_a;
    logic [N*2*DW-1:0] req_op_b;
    logic [N-1:0]      req_res_val;
    logic [N-1:0]      req_res_ready;
    logic [2*RW-1:0]   req_res;
    logic              core_op_val;
    logic              core_op_ready;
    logic [2*DW-1:0]   core_op_a;
    logic [2*DW-1:0]   core_op_b;
    logic              core_res_val;
    logic              core_res_ready;
    logic [2*RW-1:0]   core_res;
    logic              busy;
    logic [IW-1:0]     grant_id;

    always #5 clk = ~clk;

    complex_mult_arbiter #(.NR_REQ(N), .DATA_W(DW), .RES_W(RW)) u_dut (
        .clk(clk), .rst(rst), .sw_rst(sw_rst),
        .req_op_val(req_op_val), .req_op_ready(req_op_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .req_res_val(req_res_val), .req_res_ready(req_res_ready),
        .req_res(req_res),
        .core_op_val(core_op_val), .core_op_ready(core_op_ready),
        .core_op_a(core_op_a), .core_op_b(core_op_b),
        .core_res_val(core_res_val), .core_res_ready(core_res_ready),
        .core_res(core_res),
        .busy(busy), .grant_id(grant_id)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // stage: 0 idle, 1 operands to core, 2 awaiting core, 3 returning result
    logic [N-1:0]    pend;
    logic [2*DW-1:0] ra [N];
    logic [2*DW-1:0] rb [N];
    int              stage, gid, ptr, c_cnt, acc_w;
    logic [2*RW-1:0] m_res, c_res, last_res;
    logic [2*DW-1:0] m_a, m_b, sa, sb;
    bit              acc_f, op_f, res_f, ret_f;
    int              p_raise, p_drop, op_mode;
    bit              res_hold, core_hold, reraise;
    int              grants[$];

    function automatic logic [2*RW-1:0] cmul(input logic [2*DW-1:0] a,
                                             input logic [2*DW-1:0] b);
        int ar, ai, br, bi, re, im;
        ar = $signed(a[2*DW-1:DW]);
        ai = $signed(a[DW-1:0]);
        br = $signed(b[2*DW-1:DW]);
        bi = $signed(b[DW-1:0]);
        re = ar*br - ai*bi;
        im = ar*bi + ai*br;
        return {RW'(re), RW'(im)};
    endfunction

    task automatic raise(input int i);
        pend[i] = 1'b1;
        ra[i]   = 16'($urandom);
        rb[i]   = 16'($urandom);
    endtask

    task automatic model_reset();
        stage = 0; ptr = 0; gid = 0; c_cnt = 0;
        acc_f = 0; op_f = 0; res_f = 0; ret_f = 0;
    endtask

    task automatic drive();
        req_op_val = pend;
        for (int i = 0; i < N; i++) begin
            req_op_a[i*2*DW +: 2*DW] = ra[i];
            req_op_b[i*2*DW +: 2*DW] = rb[i];
        end
        core_res_val = (stage == 2 && c_cnt == 0 && !core_hold);
        core_res     = core_res_val ? c_res : ~c_res;
    endtask

    task automatic step();
        bit found;
        bit just_acc;
        int w, j;
        logic [N-1:0] exp_rdy, exp_rv;
        @(negedge clk);
        just_acc = 0;
        if (sw_rst) begin
            sw_rst = 1'b0;
            model_reset();
        end else begin
            if (ret_f) begin
                stage = 0;
                if (reraise) raise(gid);
            end
            if (res_f) stage = 3;
            if (op_f) begin
                stage = 2;
                c_cnt = $urandom_range(0, 3);
                c_res = cmul(sa, sb);
            end else if (stage == 2 && c_cnt > 0) begin
                c_cnt--;
            end
            if (acc_f) begin
                pend[acc_w] = 1'b0;
                stage = 1;
                gid   = acc_w;
                m_a   = ra[acc_w];
                m_b   = rb[acc_w];
                m_res = cmul(m_a, m_b);
                ptr   = (acc_w + 1) % N;
                just_acc = 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < p_raise) raise(i);
            else if (pend[i] && $urandom_range(0, 99) < p_drop) pend[i] = 1'b0;
        end
        req_res_ready = res_hold ? '0 : N'($urandom);
        core_op_ready = (op_mode == 1) ? 1'b0 :
                        (op_mode == 2) ? 1'b1 : ($urandom_range(0, 99) < 70);
        drive();
        #1;
        found = 0;
        w = 0;
        if (stage == 0) begin
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (!found && pend[j]) begin
                    found = 1;
                    w = j;
                end
            end
        end
        exp_rdy = found ? (N'(1) << w) : '0;
        exp_rv  = (stage == 3) ? (N'(1) << gid) : '0;
        if (just_acc) grants.push_back(int'(grant_id));
        chk("op_ready", req_op_ready, exp_rdy);
        chk("res_val", req_res_val, exp_rv);
        chk("core_op_val", core_op_val, stage == 1);
        chk("core_res_ready", core_res_ready, stage == 2);
        chk("busy", busy, stage != 0);
        chk("grant_id", grant_id, gid);
        if (stage == 1) begin
            chk("core_op_a", core_op_a, m_a);
            chk("core_op_b", core_op_b, m_b);
        end
        if (stage == 3) begin
            chk("req_res", req_res, m_res);
            last_res = req_res;
        end
        acc_f = found;
        acc_w = w;
        op_f  = (stage == 1) && core_op_ready;
        sa    = core_op_a;
        sb    = core_op_b;
        res_f = (stage == 2) && core_res_val;
        ret_f = (stage == 3) && req_res_ready[gid];
    endtask

    task automatic wait_stage(input int t, input int budget);
        for (int n = 0; n < budget && stage != t; n++) step();
        chk("wait_stage", stage, t);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && !(stage == 0 && pend == 0); n++) step();
        chk("drain", {stage != 0, pend}, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_op_ready"}, req_op_ready, 0);
        chk({tag, "_res_val"}, req_res_val, 0);
        chk({tag, "_core_op_val"}, core_op_val, 0);
        chk({tag, "_core_res_ready"}, core_res_ready, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    int gsz;

    initial begin
        rst = 1'b1; sw_rst = 1'b0;
        pend = '0; p_raise = 0; p_drop = 0; op_mode = 0;
        res_hold = 0; core_hold = 0; reraise = 0;
        c_res = '0; last_res = '0; m_a = '0; m_b = '0; m_res = '0;
        sa = '0; sb = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        req_res_ready = '0; core_op_ready = 1'b0;
        model_reset();
        drive();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_grant", grant_id, 0);
        chk("reset_op_a", core_op_a, 0);
        chk("reset_res", req_res, 0);
        rst = 1'b0;

        // all four at once, re-raising after each return
        for (int i = 0; i < N; i++) raise(i);
        reraise = 1;
        for (int n = 0; n < 300 && grants.size() < 5; n++) step();
        reraise = 0;
        chk("rr_count", grants.size() >= 5, 1);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            chk($sformatf("rr_order%0d", i), grants[i], i % N);
        drain(400);

        // single transaction with core and result back-pressure
        op_mode = 1;
        res_hold = 1;
        pend[1] = 1'b1;
        ra[1] = 16'h0304;
        rb[1] = 16'h01FE;
        wait_stage(1, 20);
        repeat (2) step();
        op_mode = 2;
        step();
        op_mode = 0;
        step();
        chk("bp_core_to_wait", core_res_ready, 1);
        wait_stage(3, 20);
        chk("t1_grant", grant_id, 1);
        raise(0); raise(2); raise(3);
        repeat (5) step();
        chk("t1_res", last_res, {18'd11, 18'h3FFFE});
        res_hold = 0;
        drain(400);

        // sw_rst while requester 2 waits on the core
        core_hold = 1;
        raise(2);
        wait_stage(2, 30);
        chk("sw_pre_grant", grant_id, 2);
        sw_rst = 1'b1;
        step();
        core_hold = 0;
        chk_all_zero("sw");
        chk("sw_grant", grant_id, 0);
        gsz = grants.size();
        raise(1); raise(2); raise(3);
        drain(200);
        chk("sw_next0", grants.size() > gsz ? grants[gsz] : -1, 1);
        chk("sw_next1", grants.size() > gsz+1 ? grants[gsz+1] : -1, 2);

        // async rst between edges while returning a result
        res_hold = 1;
        raise(3);
        wait_stage(3, 30);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("arst_now");
        pend = '0;
        drive();
        repeat (2) begin
            @(negedge clk);
            chk_all_zero("arst_hold");
        end
        res_hold = 0;
        model_reset();
        rst = 1'b0;
        gsz = grants.size();
        for (int i = 0; i < N; i++) raise(i);
        drain(300);
        chk("arst_restart", grants.size() > gsz ? grants[gsz] : -1, 0);

        // randomized traffic
        p_raise = 25;
        p_drop = 3;
        repeat (3000) step();
        p_raise = 0;
        p_drop = 0;
        drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
